// File: rtl/npc_axi_pkg.sv
// Shared AXI4-Lite response codes, channel FSM state types and default memory window base.
package npc_axi_pkg;

  localparam logic [1:0]  RESP_OKAY         = 2'b00;
  localparam logic [1:0]  RESP_SLVERR       = 2'b10;
  localparam logic [1:0]  RESP_DECERR       = 2'b11;
  localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h8000_0000;

  typedef enum logic [2:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_WAIT_W,
    W_WAIT_AW,
    W_WAIT,
    W_RESP
  } wr_state_t;

endpackage

// File: rtl/axi_lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advancing every cycle; loads seed during reset.
module axi_lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_q <= seed;
    else      r_q <= {r_q[6:0], r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3]};
  end

  assign q = r_q;

endmodule

// File: rtl/axi_lite_sram.sv
// AXI4-Lite single-beat SRAM slave with independent read/write FSMs and DECERR outside the window.
// Define RANDOM_DELAY_EN to add LFSR-driven per-transaction response latency.
module axi_lite_sram
  import npc_axi_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned DELAY_BITS  = 3,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) << 2;

  logic [31:0] r_mem [DEPTH_WORDS];

  rd_state_t r_rstate, w_rnext;
  wr_state_t r_wstate, w_wnext;

  logic                  r_arready, r_rvalid, r_awready, r_wready, r_bvalid;
  logic [31:0]           r_rdata, r_araddr, r_awaddr, r_wdata;
  logic [1:0]            r_rresp, r_bresp;
  logic [3:0]            r_wstrb;
  logic [DELAY_BITS-1:0] r_rcnt, r_wcnt;

  logic [DELAY_BITS-1:0] w_delay;
  logic [31:0]           w_roff, w_woff;
  logic                  w_rok, w_wok, w_ar_hs, w_aw_hs, w_w_hs, w_mem_we;
  logic [IDX_W-1:0]      w_ridx, w_widx;

`ifdef RANDOM_DELAY_EN
  logic [7:0] w_lfsr;
  logic       w_unused_lfsr;

  axi_lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (w_lfsr)
  );

  assign w_delay       = w_lfsr[DELAY_BITS-1:0];
  assign w_unused_lfsr = ^w_lfsr;
`else
  assign w_delay = '0;
`endif

  // Unsigned offset wraps below ADDR_BASE, so one compare covers both window edges.
  assign w_roff = r_araddr - ADDR_BASE;
  assign w_woff = r_awaddr - ADDR_BASE;
  assign w_rok  = {1'b0, w_roff} < WIN_BYTES;
  assign w_wok  = {1'b0, w_woff} < WIN_BYTES;
  assign w_ridx = w_roff[IDX_W+1:2];
  assign w_widx = w_woff[IDX_W+1:2];

  assign w_ar_hs  = arvalid && r_arready;
  assign w_aw_hs  = awvalid && r_awready;
  assign w_w_hs   = wvalid  && r_wready;
  assign w_mem_we = (r_wstate == W_WAIT) && (r_wcnt == '0) && w_wok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rstate <= R_IDLE;
    else      r_rstate <= w_rnext;
  end

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rnext = R_WAIT;
      R_WAIT:  if (r_rcnt == '0) w_rnext = R_RESP;
      R_RESP:  if (rready) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  // Read datapath; the array is sampled before any same-edge write lands (read-first).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_araddr  <= '0;
      r_rcnt    <= '0;
    end else begin
      r_arready <= (w_rnext == R_IDLE);
      r_rvalid  <= (w_rnext == R_RESP);
      if (w_ar_hs) begin
        r_araddr <= araddr;
        r_rcnt   <= w_delay;
      end else if (r_rstate == R_WAIT) begin
        if (r_rcnt != '0) begin
          r_rcnt <= r_rcnt - DELAY_BITS'(1);
        end else begin
          r_rdata <= w_rok ? r_mem[w_ridx] : '0;
          r_rresp <= w_rok ? RESP_OKAY : RESP_DECERR;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wstate <= W_IDLE;
    else      r_wstate <= w_wnext;
  end

  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) w_wnext = W_WAIT;
        else if (w_aw_hs)      w_wnext = W_WAIT_W;
        else if (w_w_hs)       w_wnext = W_WAIT_AW;
      end
      W_WAIT_W:  if (w_w_hs)  w_wnext = W_WAIT;
      W_WAIT_AW: if (w_aw_hs) w_wnext = W_WAIT;
      W_WAIT:    if (r_wcnt == '0) w_wnext = W_RESP;
      W_RESP:    if (bready) w_wnext = W_IDLE;
      default:   w_wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_wcnt    <= '0;
    end else begin
      r_awready <= (w_wnext == W_IDLE) || (w_wnext == W_WAIT_AW);
      r_wready  <= (w_wnext == W_IDLE) || (w_wnext == W_WAIT_W);
      r_bvalid  <= (w_wnext == W_RESP);
      if (w_aw_hs) r_awaddr <= awaddr;
      if (w_w_hs) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      if ((w_wnext == W_WAIT) && (r_wstate != W_WAIT)) begin
        r_wcnt <= w_delay;
      end else if (r_wstate == W_WAIT) begin
        if (r_wcnt != '0) r_wcnt <= r_wcnt - DELAY_BITS'(1);
        else              r_bresp <= w_wok ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (r_wstrb[b]) r_mem[w_widx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;

endmodule

// File: tb/tb_axi_lite_sram.sv
// Directed bench for axi_lite_sram: reset, full/partial/split writes, decode errors, backpressure.
module tb_axi_lite_sram;

  logic        clk, rst;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] d;
  logic [1:0]  r;

  axi_lite_sram dut (
    .clk     (clk),
    .rst     (rst),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] dat, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    chk("ar_handshake", 64'(arready), 64'd1);
    @(posedge clk); #1 arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    chk("r_valid_seen", 64'(rvalid), 64'd1);
    dat = rdata; resp = rresp;
    @(posedge clk); #1;
  endtask

  // order: 0 = AW and W together, 1 = W one cycle before AW, 2 = AW one cycle before W
  task automatic wr(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s,
                    input int order, output logic [1:0] resp);
    bit ad, wd, ah, wh;
    int n;
    awaddr = a; wdata = dat; wstrb = s; bready = 1'b1;
    ad = 1'b0; wd = 1'b0;
    awvalid = (order != 1);
    wvalid  = (order != 2);
    n = 0;
    while (!(ad && wd) && n < 50) begin
      @(negedge clk);
      ah = awvalid && awready;
      wh = wvalid && wready;
      @(posedge clk); #1;
      if (ah) begin awvalid = 1'b0; ad = 1'b1; end
      if (wh) begin wvalid = 1'b0; wd = 1'b1; end
      if (ad && !wd) wvalid = 1'b1;
      if (wd && !ad) awvalid = 1'b1;
      n++;
    end
    chk("aw_w_handshake", 64'({ad, wd}), 64'b11);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    chk("b_valid_seen", 64'(bvalid), 64'd1);
    resp = bresp;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("reset_outputs", 64'({arready, awready, wready, rvalid, bvalid, rresp, bresp, rdata}), 64'd0);
    @(negedge clk) rst = 1'b1;
    #1 chk("arready_before_first_edge", 64'(arready), 64'd0);
    @(posedge clk);
    #1 chk("readies_after_first_edge", 64'({arready, awready, wready}), 64'b111);

    // Array survives reset: write word 4, reset with AR pending, then read it back
    wr(32'h8000_0010, 32'hCAFE_F00D, 4'hF, 0, r);
    chk("wr_w4_bresp", 64'(r), 64'd0);
    araddr = 32'h8000_0010; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk) rst = 1'b0;
    #1 chk("reset2_outputs", 64'({arready, awready, wready, rvalid, bvalid, rresp, bresp, rdata}), 64'd0);
    @(negedge clk) rst = 1'b1;
    #1 chk("arready_low_after_release", 64'(arready), 64'd0);
    @(posedge clk);
    #1 chk("arready_high_after_edge", 64'(arready), 64'd1);
    rd(32'h8000_0010, d, r);
    chk("rd_w4_resp", 64'(r), 64'd0);
    chk("rd_w4_data", 64'(d), 64'hCAFE_F00D);

    // Full write then read
    wr(32'h8000_0020, 32'hDEAD_BEEF, 4'hF, 0, r);
    chk("wr_20_bresp", 64'(r), 64'd0);
    rd(32'h8000_0020, d, r);
    chk("rd_20_resp", 64'(r), 64'd0);
    chk("rd_20_data", 64'(d), 64'hDEAD_BEEF);

    // Partial write, W before AW
    wr(32'h8000_0030, 32'h1122_3344, 4'hF, 0, r);
    wr(32'h8000_0030, 32'h5566_7788, 4'b0101, 1, r);
    chk("wr_30_wfirst_bresp", 64'(r), 64'd0);
    rd(32'h8000_0030, d, r);
    chk("rd_30_merged", 64'(d), 64'h1166_3388);

    // Partial write, AW before W
    wr(32'h8000_0034, 32'h0000_0000, 4'hF, 0, r);
    wr(32'h8000_0034, 32'hAABB_CCDD, 4'b1010, 2, r);
    chk("wr_34_awfirst_bresp", 64'(r), 64'd0);
    rd(32'h8000_0034, d, r);
    chk("rd_34_merged", 64'(d), 64'hAA00_CC00);

    // wstrb=0 is an OKAY no-op; low address bits are ignored
    wr(32'h8000_0020, 32'h0000_0000, 4'h0, 0, r);
    chk("wr_strb0_bresp", 64'(r), 64'd0);
    rd(32'h8000_0023, d, r);
    chk("rd_23_unaligned", 64'({r, d}), {30'd0, 2'b00, 32'hDEAD_BEEF});

    // Decode errors and window edges
    wr(32'h8000_0000, 32'h0102_0304, 4'hF, 0, r);
    rd(32'h7FFF_FFFC, d, r);
    chk("rd_below_resp", 64'(r), 64'd3);
    chk("rd_below_data", 64'(d), 64'd0);
    wr(32'h9000_0000, 32'hFFFF_FFFF, 4'hF, 0, r);
    chk("wr_above_bresp", 64'(r), 64'd3);
    rd(32'h8000_0000, d, r);
    chk("rd_w0_unchanged", 64'(d), 64'h0102_0304);
    wr(32'h8000_3FFC, 32'h5A5A_0001, 4'hF, 0, r);
    chk("wr_last_bresp", 64'(r), 64'd0);
    rd(32'h8000_3FFC, d, r);
    chk("rd_last_word", 64'({r, d}), {30'd0, 2'b00, 32'h5A5A_0001});
    rd(32'h8000_4000, d, r);
    chk("rd_past_end", 64'({r, d}), {30'd0, 2'b11, 32'd0});

    // Backpressure on R
    araddr = 32'h8000_0020; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1 arvalid = 1'b0;
    chk("bp_no_rvalid_at_hs", 64'(rvalid), 64'd0);
`ifndef RANDOM_DELAY_EN
    @(posedge clk);
    #1 chk("bp_min_latency", 64'(rvalid), 64'd1);
`endif
    for (int i = 0; i < 50 && !rvalid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", 64'({rvalid, arready, rresp, rdata}), {28'd0, 1'b1, 1'b0, 2'b00, 32'hDEAD_BEEF});
    end
    rready = 1'b1;
    @(posedge clk);
    #1 chk("bp_release", 64'({rvalid, arready}), 64'b01);

`ifndef RANDOM_DELAY_EN
    // Same word read and written on the same edge returns the old data
    wr(32'h8000_0040, 32'h0000_1111, 4'hF, 0, r);
    araddr = 32'h8000_0040; arvalid = 1'b1;
    awaddr = 32'h8000_0040; wdata = 32'h2222_0000; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1 begin arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; end
    @(posedge clk);
    #1 chk("rw_same_edge", 64'({rvalid, bvalid, rresp, bresp, rdata}), {26'd0, 6'b110000, 32'h0000_1111});
    @(posedge clk); #1;
    rd(32'h8000_0040, d, r);
    chk("rd_40_after_rw", 64'(d), 64'h2222_0000);
`endif

    // Reset while both channels are mid-transaction
    wr(32'h8000_0050, 32'h1357_9BDF, 4'hF, 0, r);
    araddr = 32'h8000_0050; arvalid = 1'b1;
    awaddr = 32'h8000_0050; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1 begin arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; end
    rst = 1'b0;
    #1 chk("mid_reset_outputs", 64'({arready, awready, wready, rvalid, bvalid, rresp, bresp, rdata}), 64'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 chk("mid_reset_idle", 64'({arready, awready, wready, rvalid, bvalid}), 64'b11100);
    rd(32'h8000_0050, d, r);
    chk("rd_50_uncommitted", 64'(d), 64'h1357_9BDF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
